dmem_responder: RTL

//  Memory-side responder for the CPU's load/store requests: the other end of the controller's

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_lane_fmt.sv | 79 +++++++
 rtl/dmem_responder.sv | 115 +++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder: RV32I load/store funct3 values and FSM states.
package dmem_responder_pkg;

    localparam logic [2:0] Funct3B  = 3'b000;
    localparam logic [2:0] Funct3H  = 3'b001;
    localparam logic [2:0] Funct3W  = 3'b010;
    localparam logic [2:0] Funct3Bu = 3'b100;
    localparam logic [2:0] Funct3Hu = 3'b101;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: request fault check, store byte enables / data replication,
// and load byte/half extraction with sign or zero extension.
module dmem_lane_fmt
    import dmem_responder_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] mem_rdata_i,
    output logic        fault_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o
);

    logic       illegal_f3;
    logic       misaligned;
    logic       out_of_range;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Anything above the SRAM's byte range is rejected rather than aliased.
    assign out_of_range = (addr_i >> (AW + 2)) != 32'd0;
    assign fault_o      = illegal_f3 | misaligned | out_of_range;

    always_comb begin
        illegal_f3 = 1'b0;
        misaligned = 1'b0;
        case (funct3_i)
            Funct3B:  illegal_f3 = 1'b0;
            Funct3H:  misaligned = addr_i[0];
            Funct3W:  misaligned = (addr_i[1:0] != 2'b00);
            Funct3Bu: illegal_f3 = we_i;
            Funct3Hu: begin
                illegal_f3 = we_i;
                misaligned = addr_i[0];
            end
            default:  illegal_f3 = 1'b1;
        endcase
    end

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        case (funct3_i)
            Funct3B: begin
                be_o    = 4'b0001 << addr_i[1:0];
                wdata_o = {4{wdata_i[7:0]}};
            end
            Funct3H: begin
                be_o    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            Funct3W: be_o = 4'b1111;
            default: be_o = 4'b0000;
        endcase
    end

    assign ld_byte = mem_rdata_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = mem_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = 32'd0;
        case (ld_funct3_i)
            Funct3B:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            Funct3H:  ld_data_o = {{16{ld_half[15]}}, ld_half};
            Funct3W:  ld_data_o = mem_rdata_i;
            Funct3Bu: ld_data_o = {24'd0, ld_byte};
            Funct3Hu: ld_data_o = {16'd0, ld_half};
            default:  ld_data_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for CPU loads/stores: accepts one request at a time, drives a
// synchronous word SRAM with byte enables and returns load data, store ack or fault.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_fault,
    output logic          mem_en,
    output logic [3:0]    mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_fault_q, rsp_fault_d;

    logic        accept;
    logic        fmt_fault;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_ld_data;

    dmem_lane_fmt #(
        .AW(AW)
    ) u_lane_fmt (
        .we_i        (req_we),
        .funct3_i    (req_funct3),
        .addr_i      (req_addr),
        .wdata_i     (req_wdata),
        .ld_funct3_i (ld_funct3_q),
        .ld_off_i    (ld_off_q),
        .mem_rdata_i (mem_rdata),
        .fault_o     (fmt_fault),
        .be_o        (fmt_be),
        .wdata_o     (fmt_wdata),
        .ld_data_o   (fmt_ld_data)
    );

    // Reset overrides a concurrent request so nothing reaches the SRAM that cycle.
    assign accept    = (state_q == StIdle) && req_valid && !reset;
    assign req_ready = (state_q == StIdle) && !reset;
    assign rsp_valid = (state_q == StResp) && !reset;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign mem_addr  = req_addr[AW+1:2];
    assign mem_wdata = fmt_wdata;

    always_comb begin
        state_d     = state_q;
        ld_funct3_d = ld_funct3_q;
        ld_off_d    = ld_off_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        mem_en      = 1'b0;
        mem_we      = 4'b0000;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d     = StResp;
                    rsp_rdata_d = 32'd0;
                    rsp_fault_d = fmt_fault;
                    if (!fmt_fault) begin
                        mem_en = 1'b1;
                        if (req_we) begin
                            mem_we = fmt_be;
                        end else begin
                            state_d     = StLoad;
                            ld_funct3_d = req_funct3;
                            ld_off_d    = req_addr[1:0];
                        end
                    end
                end
            end
            StLoad: begin
                rsp_rdata_d = fmt_ld_data;
                state_d     = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            ld_funct3_q <= 3'd0;
            ld_off_q    <= 2'd0;
            rsp_rdata_q <= 32'd0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ld_funct3_q <= ld_funct3_d;
            ld_off_q    <= ld_off_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

endmodule
